// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default operand width and the serial
// controller state encoding.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor; master drives
// operands and consumes results, slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = arith_pkg::DEFAULT_WIDTH
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both high. A source holds valid and its payload until that edge; the
  // payload is only meaningful while valid is high.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, zero
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, Bout is the borrow out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Bout,
  output logic D
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB-first through a
// single full-subtractor cell, with borrow/overflow/zero flags.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus,
  output state_t              state_dbg
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             bin_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_valid_q;
  logic             d_bit;
  logic             bout_bit;
  logic             accept;
  logic             last_bit;
  logic             release_out;

  full_subtractor u_fs (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (bin_q),
    .Bout (bout_bit),
    .D    (d_bit)
  );

  assign accept      = (state_q == IDLE) & bus.in_valid;
  assign last_bit    = (state_q == SHIFT) & (count_q == CNT_W'(WIDTH - 1));
  assign release_out = (state_q == DONE) & out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = SHIFT;
      SHIFT:   if (last_bit)    state_d = DONE;
      DONE:    if (release_out) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      bin_q       <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            res_q   <= '0;
            bin_q   <= 1'b0;
            count_q <= '0;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res_q <= {d_bit, res_q[WIDTH-1:1]};
          bin_q <= bout_bit;
          if (!last_bit) count_q <= count_q + CNT_W'(1);
        end
        DONE: begin
          // First DONE cycle publishes the completed result and its flags;
          // afterwards everything is held until the consumer takes it.
          if (!out_valid_q) begin
            diff_q      <= res_q;
            borrow_q    <= bin_q;
            ovf_q       <= (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
            zero_q      <= (res_q == '0);
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed and random
// operations, backpressure, mid-operation reset.
module tb_serial_subtractor;
  import arith_pkg::*;

  localparam int W = 8;

  logic   clk = 1'b0;
  logic   reset;
  state_t state_dbg;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {diff, borrow, ovf, zero}
  logic [W+2:0] exp_q[$];

  function automatic logic [W+2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] d;
    logic         brw;
    logic         ov;
    logic         z;
    d   = av - bv;
    brw = (av < bv);
    ov  = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
    z   = (d == '0);
    return {d, brw, ov, z};
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
    int           n;
    bit           busy_ok;
    logic [W+2:0] exp_v;
    logic [W+2:0] act_v;
    @(negedge clk);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_wait act=%b exp=1", bus.in_ready);
    end
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(av, bv));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    n       = 0;
    busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
    checks++;
    if (n != W + 1) begin
      failures++;
      $display("FAIL latency a=%h b=%h act=%0d exp=%0d", av, bv, n, W + 1);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL busy_in_ready a=%h b=%h act=1 exp=0", av, bv);
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty act=0 exp=1");
      return;
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(negedge clk);
      act_v = {bus.diff, bus.borrow, bus.ovf, bus.zero};
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || state_dbg !== DONE ||
          act_v !== exp_q[0]) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d act_v=%b act_ir=%b act_res=%h exp_res=%h",
                 i, bus.out_valid, bus.in_ready, act_v, exp_q[0]);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp_v = exp_q.pop_front();
    act_v = {bus.diff, bus.borrow, bus.ovf, bus.zero};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL result a=%h b=%h act diff=%h brw=%b ovf=%b z=%b exp diff=%h brw=%b ovf=%b z=%b",
               av, bv, act_v[W+2:3], act_v[2], act_v[1], act_v[0],
               exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== exp_v[W+2:3]) begin
      failures++;
      $display("FAIL release act_v=%b act_ir=%b act_diff=%h exp_v=0 exp_ir=1 exp_diff=%h",
               bus.out_valid, bus.in_ready, bus.diff, exp_v[W+2:3]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== '0 ||
        bus.borrow !== 1'b0 || bus.ovf !== 1'b0 || bus.zero !== 1'b0 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL reset_values act ir=%b ov=%b diff=%h b=%b o=%b z=%b exp ir=1 ov=0 diff=00 b=0 o=0 z=0",
               bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero);
    end
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (state_dbg !== IDLE || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_out_ready act_state=%0d act_ov=%b exp_state=0 exp_ov=0",
               state_dbg, bus.out_valid);
    end
  endtask

  task automatic test_basic;
    run_op(8'h05, 8'h03, 0);
    run_op(8'h03, 8'h05, 0);
  endtask

  task automatic test_overflow;
    run_op(8'h80, 8'h01, 0);
    run_op(8'h7F, 8'hFF, 0);
  endtask

  task automatic test_zero;
    run_op(8'h2A, 8'h2A, 0);
    run_op(8'h00, 8'h00, 0);
  endtask

  task automatic test_backpressure;
    run_op(8'hC3, 8'h5A, 5);
    run_op(8'h11, 8'h22, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++)
      run_op(W'($urandom), W'($urandom), $urandom_range(0, 2));
  endtask

  task automatic test_reset_mid_shift;
    int n;
    @(negedge clk);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    bus.a        = 8'hF0;
    bus.b        = 8'h0F;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== '0 ||
        bus.borrow !== 1'b0 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL mid_shift_reset act ir=%b ov=%b diff=%h b=%b st=%0d exp ir=1 ov=0 diff=00 b=0 st=0",
               bus.in_ready, bus.out_valid, bus.diff, bus.borrow, state_dbg);
    end
    run_op(8'h10, 8'h01, 0);
  endtask

  task automatic test_reset_with_valid;
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 8'h55;
    bus.b        = 8'h11;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (state_dbg !== IDLE || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_vs_valid act_state=%0d act_ir=%b exp_state=0 exp_ir=1",
               state_dbg, bus.in_ready);
    end
    run_op(8'h55, 8'h11, 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_reset_with_valid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
